sram16k_wb_ctrl: RTL and testbench

Wishbone classic slave that acts as the initiator side of the 16 KB SRAM array port (4096 × 32-bit words, 8 banks of 512 words). It translates bus cycles into single-cycle SRAM strobes, absorbs the array's one-cycle registered read latency, and returns `wbs_ack_o`. After reset it can optionally zero-fill the whole array before it accepts traffic. It sits between the user-project Wishbone bus and the SRAM array.

---
 rtl/sram16k_wb_ctrl_if.sv | 32 +++
 rtl/sram16k_wb_ctrl.sv | 86 ++++++++
 tb/tb_sram16k_wb_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sram16k_wb_ctrl_if.sv
// Bus bundle between a Wishbone master and the SRAM controller, plus the
// controller's array-side strobes; the controller uses the slave modport.
interface sram16k_wb_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        busy;
  logic        sram_cs;
  logic [11:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_wen;
  logic [31:0] sram_rdata;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o, busy,
    output sram_cs, sram_addr, sram_wdata, sram_wen,
    input  sram_rdata
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o, busy,
    input  sram_cs, sram_addr, sram_wdata, sram_wen,
    output sram_rdata
  );
endinterface

// File: rtl/sram16k_wb_ctrl.sv
// Wishbone classic slave driving a 4096x32 SRAM with registered read data;
// optionally zero-fills the array after reset before taking bus traffic.
module sram16k_wb_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  sram16k_wb_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RD, S_ACK} state_t;

  state_t      state, state_nxt;
  logic [11:0] ic;
  logic        hit;
  logic        cs;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wen;
  logic        ack_p1;
  logic [31:0] rdat_p1;
  logic [1:0]  unused_adr;

  assign unused_adr = bus.wbs_adr_i[1:0];
  assign hit = bus.wbs_cyc_i & bus.wbs_stb_i &
               (bus.wbs_adr_i[31:14] == BASE_ADDR[31:14]);

  always_comb begin
    state_nxt = state;
    cs        = 1'b0;
    addr      = bus.wbs_adr_i[13:2];
    wdata     = bus.wbs_dat_i;
    wen       = 4'h0;
    unique case (state)
      S_INIT: begin
        cs    = 1'b1;
        addr  = ic;
        wdata = 32'h0;
        wen   = 4'hF;
        if (ic == 12'hFFF) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (hit) begin
          if (bus.wbs_we_i) begin
            // An all-lanes-off write is acknowledged without touching the array
            cs        = |bus.wbs_sel_i;
            wen       = bus.wbs_sel_i;
            state_nxt = S_ACK;
          end else begin
            cs        = 1'b1;
            state_nxt = S_RD;
          end
        end
      end
      S_RD:  state_nxt = S_ACK;
      // ACK parks one cycle so the still-held strobe is not re-issued
      S_ACK: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p1: state, fill counter, registered ack and read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT_ZERO ? S_INIT : S_IDLE;
      ic      <= 12'h0;
      ack_p1  <= 1'b0;
      rdat_p1 <= 32'h0;
    end else begin
      state  <= state_nxt;
      if (state == S_INIT) ic <= ic + 12'd1;
      ack_p1 <= (state_nxt == S_ACK) & bus.wbs_cyc_i;
      if (state == S_RD) rdat_p1 <= bus.sram_rdata;
    end
  end

  assign bus.sram_cs    = cs;
  assign bus.sram_addr  = addr;
  assign bus.sram_wdata = wdata;
  assign bus.sram_wen   = wen;
  assign bus.wbs_ack_o  = ack_p1;
  assign bus.wbs_dat_o  = rdat_p1;
  assign bus.busy       = (state == S_INIT);

endmodule

// File: tb/tb_sram16k_wb_ctrl.sv
// Directed bench for sram16k_wb_ctrl with a behavioural registered-read SRAM.
module tb_sram16k_wb_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [31:0] mem [4096];

  sram16k_wb_ctrl_if bus ();

  sram16k_wb_ctrl #(.BASE_ADDR(32'h3000_0000), .INIT_ZERO(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Array model: byte-lane writes, one-cycle registered read
  always @(posedge clk) begin
    if (bus.sram_cs) begin
      if (bus.sram_wen == 4'h0) begin
        bus.sram_rdata <= mem[bus.sram_addr];
      end else begin
        for (int b = 0; b < 4; b++)
          if (bus.sram_wen[b]) mem[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat, output int lat,
                         output logic cs0, output logic [11:0] addr0, output logic [3:0] wen0);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    lat = -1; rdat = '0; cs0 = 1'b0; addr0 = '0; wen0 = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        cs0 = bus.sram_cs; addr0 = bus.sram_addr; wen0 = bus.sram_wen;
      end
      if (bus.wbs_ack_o) begin
        lat = k; rdat = bus.wbs_dat_o;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  logic [31:0] rd;
  int          lat, busy_cnt, ack_c, early, cs_cnt;
  logic        cs0;
  logic [11:0] a0;
  logic [3:0]  w0;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0000 | i;
    bus.sram_rdata = 32'h0;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    bus.wbs_sel_i = 0; bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    // Read of word 0 held from the first post-reset cycle through the fill
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_adr_i = 32'h3000_0000;
    busy_cnt = 0; ack_c = -1; early = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("rst_busy", 32'(bus.busy), 32'd1);
        check("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
        check("rst_dat", bus.wbs_dat_o, 32'h0);
        check("fill_addr0", 32'(bus.sram_addr), 32'd0);
        check("fill_strobe0", {bus.sram_cs, bus.sram_wen, bus.sram_wdata[26:0]}, {1'b1, 4'hF, 27'h0});
      end
      if (c == 5) check("fill_addr5", 32'(bus.sram_addr), 32'd5);
      if (bus.busy) begin
        busy_cnt++;
        if (bus.wbs_ack_o) early++;
      end
      if (bus.wbs_ack_o) begin
        ack_c = c; rd = bus.wbs_dat_o;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    check("busy_cycles", busy_cnt, 4096);
    check("init_early_ack", early, 0);
    check("held_ack_cycle", ack_c, 4098);
    check("rd_w0", rd, 32'h0);

    wb_xfer(0, 32'h3000_1FFC, 0, 4'hF, rd, lat, cs0, a0, w0);
    check("rd_w2047", rd, 32'h0);
    check("rd_w2047_lat", lat, 2);
    wb_xfer(0, 32'h3000_3FFC, 0, 4'hF, rd, lat, cs0, a0, w0);
    check("rd_w4095", rd, 32'h0);
    check("rd_w4095_lat", lat, 2);

    wb_xfer(1, 32'h3000_0010, 32'hDEADBEEF, 4'hF, rd, lat, cs0, a0, w0);
    check("wr_lat", lat, 1);
    check("wr_strobe", {cs0, a0, w0}, {1'b1, 12'h004, 4'hF});
    wb_xfer(0, 32'h3000_0010, 0, 4'hF, rd, lat, cs0, a0, w0);
    check("rd_beef", rd, 32'hDEADBEEF);
    check("rd_beef_strobe", {cs0, a0, w0}, {1'b1, 12'h004, 4'h0});
    wb_xfer(0, 32'h3000_0013, 0, 4'h0, rd, lat, cs0, a0, w0);
    check("rd_lowbits_ignored", rd, 32'hDEADBEEF);

    wb_xfer(1, 32'h3000_0020, 32'h11223344, 4'hF, rd, lat, cs0, a0, w0);
    wb_xfer(1, 32'h3000_0020, 32'hAABBCCDD, 4'b0101, rd, lat, cs0, a0, w0);
    wb_xfer(0, 32'h3000_0020, 0, 4'hF, rd, lat, cs0, a0, w0);
    check("rd_bytelanes", rd, 32'h11BB33DD);

    wb_xfer(1, 32'h3000_0014, 32'h12345678, 4'hF, rd, lat, cs0, a0, w0);
    wb_xfer(1, 32'h3000_0014, 32'hFFFF_FFFF, 4'h0, rd, lat, cs0, a0, w0);
    check("sel0_lat", lat, 1);
    check("sel0_cs", 32'(cs0), 32'd0);
    check("dat_hold_after_wr", bus.wbs_dat_o, 32'h11BB33DD);
    wb_xfer(0, 32'h3000_0014, 0, 4'hF, rd, lat, cs0, a0, w0);
    check("rd_sel0_kept", rd, 32'h12345678);

    // Miss window: never acked, never strobes the array
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = 32'h3100_0000;
    early = 0; cs_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) early++;
      if (bus.sram_cs) cs_cnt++;
      @(posedge clk); #1;
    end
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    check("miss_ack", early, 0);
    check("miss_cs", cs_cnt, 0);

    // Drop cyc while in RD: silent pass through ACK, IDLE two cycles later
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = 32'h3000_0010;
    @(posedge clk); #1;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    early = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) early++;
      @(posedge clk); #1;
    end
    check("cycdrop_ack", early, 0);
    wb_xfer(1, 32'h3000_0024, 32'hCAFEF00D, 4'hF, rd, lat, cs0, a0, w0);
    check("cycdrop_idle_lat", lat, 1);
    wb_xfer(0, 32'h3000_0024, 0, 4'hF, rd, lat, cs0, a0, w0);
    check("rd_cafe", rd, 32'hCAFEF00D);

    // Reset during RD: no ack next cycle, fill restarts
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = 32'h3000_0024;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstrd_ack", 32'(bus.wbs_ack_o), 32'd0);
    check("rstrd_busy", 32'(bus.busy), 32'd1);
    check("rstrd_fill_addr", 32'(bus.sram_addr), 32'd0);
    busy_cnt = 0;
    for (int c = 0; c < 5000; c++) begin
      if (!bus.busy) break;
      busy_cnt++;
      @(negedge clk);
    end
    check("refill_cycles", busy_cnt, 4096);
    @(posedge clk); #1;
    wb_xfer(0, 32'h3000_0024, 0, 4'hF, rd, lat, cs0, a0, w0);
    check("refill_cleared", rd, 32'h0);
    check("refill_rd_lat", lat, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
